// File: rtl/pipe_tx_framer_pkg.sv
// Shared types and PIPE symbol encodings for the transmit framer.
package pipe_tx_framer_pkg;

  typedef enum logic [2:0] {
    DETECT_state,
    POLLING_state,
    CONFIG_state,
    ACTIVE_state,
    RETRAIN_state,
    DISABLED_state
  } state_t;

  typedef bit [47:0] dllp_flat_t;

  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] D_IDL = 8'h00;

  typedef enum logic [2:0] {
    StIdle,
    StDllp,
    StTlp,
    StEndSpill,
    StAbort
  } tx_fsm_e;

endpackage

// File: rtl/pipe_tx_byte_packer.sv
// Packs lead/carry symbol, TLP bytes and END into PIPE lanes with IDL fill; registers TxData/K.
module pipe_tx_byte_packer
  import pipe_tx_framer_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned NbW        = $clog2(DATA_BYTES) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    raw_en_i,
  input  logic [8*DATA_BYTES-1:0] raw_data_i,
  input  logic [DATA_BYTES-1:0]   raw_k_i,
  input  logic                    lead_en_i,
  input  logic                    beat_en_i,
  input  logic                    beat_last_i,
  input  logic [NbW-1:0]          beat_nbytes_i,
  input  logic [8*DATA_BYTES-1:0] beat_data_i,
  input  logic                    end_en_i,
  output logic                    end_pend_o,
  output logic [8*DATA_BYTES-1:0] tx_data_o,
  output logic [DATA_BYTES-1:0]   tx_datak_o
);

  localparam int unsigned Slots = DATA_BYTES + 2;
  localparam int unsigned IdxW  = $clog2(Slots);

  logic [7:0]              sym [Slots];
  logic [Slots-1:0]        symk, symd;
  logic [IdxW-1:0]         idx;
  int unsigned             nb;
  logic [7:0]              carry_q, carry_d;
  logic                    carry_v_q, carry_v_d;
  logic [8*DATA_BYTES-1:0] tx_data_q, tx_data_d;
  logic [DATA_BYTES-1:0]   tx_datak_q, tx_datak_d;

  always_comb begin
    for (int unsigned s = 0; s < Slots; s++) begin
      sym[s]  = D_IDL;
      symk[s] = 1'b0;
      symd[s] = 1'b0;
    end
    idx = '0;
    nb  = beat_last_i ? 32'(beat_nbytes_i) : DATA_BYTES;
    if (lead_en_i) begin
      sym[0]  = K_STP;
      symk[0] = 1'b1;
      idx     = IdxW'(1);
    end else if (carry_v_q) begin
      sym[0]  = carry_q;
      symd[0] = 1'b1;
      idx     = IdxW'(1);
    end
    if (beat_en_i) begin
      for (int unsigned i = 0; i < DATA_BYTES; i++) begin
        if (i < nb) begin
          sym[idx]  = beat_data_i[8*i+:8];
          symd[idx] = 1'b1;
          idx       = idx + IdxW'(1);
        end
      end
    end
    if (end_en_i) begin
      sym[idx]  = K_END;
      symk[idx] = 1'b1;
    end
    // Anything past lane DATA_BYTES-1 spills: a data byte becomes the carry, an END stays pending.
    end_pend_o = |symk[Slots-1:DATA_BYTES];
    carry_d    = sym[DATA_BYTES];
    carry_v_d  = symd[DATA_BYTES] && !raw_en_i;
    for (int unsigned b = 0; b < DATA_BYTES; b++) begin
      tx_data_d[8*b+:8] = sym[b];
      tx_datak_d[b]     = symk[b];
    end
    if (raw_en_i) begin
      tx_data_d  = raw_data_i;
      tx_datak_d = raw_k_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      carry_q    <= '0;
      carry_v_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_datak_q <= '0;
    end else begin
      carry_q    <= carry_d;
      carry_v_q  <= carry_v_d;
      tx_data_q  <= tx_data_d;
      tx_datak_q <= tx_datak_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_datak_o = tx_datak_q;

endmodule

// File: rtl/pipe_tx_framer.sv
// Gen1/Gen2 PIPE transmit framer: DLLP/TLP framing FSM and handshakes around the byte packer.
module pipe_tx_framer
  import pipe_tx_framer_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 4
) (
  input  logic                          pclk,
  input  logic                          reset,
  input  state_t                        link_state,
  input  logic                          dllp_valid,
  output logic                          dllp_ready,
  input  dllp_flat_t                    dllp_data,
  input  logic                          tlp_valid,
  output logic                          tlp_ready,
  input  logic [8*DATA_BYTES-1:0]       tlp_data,
  input  logic                          tlp_last,
  input  logic [$clog2(DATA_BYTES):0]   tlp_nbytes,
  output logic [8*DATA_BYTES-1:0]       tx_data,
  output logic [DATA_BYTES-1:0]         tx_datak,
  output logic                          frame_abort
);

  localparam int unsigned NbW     = $clog2(DATA_BYTES) + 1;
  localparam logic [2:0]  CntInit = 3'(8 / DATA_BYTES - 1);
  localparam logic [7:0]  DllpK   = 8'h81;

  tx_fsm_e                 st_q, st_d;
  logic                    active, dllp_fire, tlp_fire, abort_now;
  logic [63:0]             dllp_sym, dllp_q;
  logic [7:0]              dllp_kq;
  logic [2:0]              cnt_q;
  logic                    frame_abort_q;
  logic                    pk_raw_en, pk_lead_en, pk_beat_en, pk_end_en, pk_end_pend;
  logic [8*DATA_BYTES-1:0] pk_raw_data;
  logic [DATA_BYTES-1:0]   pk_raw_k;

  assign active    = (link_state == ACTIVE_state);
  assign dllp_fire = dllp_valid && dllp_ready;
  assign tlp_fire  = tlp_valid && tlp_ready;
  assign dllp_sym  = {K_END, dllp_data, K_SDP};
  assign abort_now = !active && (st_q == StDllp || st_q == StTlp || st_q == StEndSpill);

  always_ff @(posedge pclk) begin
    if (reset) begin
      st_q          <= StIdle;
      frame_abort_q <= 1'b0;
    end else begin
      st_q          <= st_d;
      frame_abort_q <= abort_now;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      dllp_q  <= '0;
      dllp_kq <= '0;
      cnt_q   <= '0;
    end else if (dllp_fire) begin
      dllp_q  <= dllp_sym >> (8 * DATA_BYTES);
      dllp_kq <= DllpK >> DATA_BYTES;
      cnt_q   <= CntInit;
    end else if (st_q == StDllp) begin
      dllp_q  <= dllp_q >> (8 * DATA_BYTES);
      dllp_kq <= dllp_kq >> DATA_BYTES;
      cnt_q   <= cnt_q - 3'd1;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StIdle: begin
        if (dllp_fire) begin
          st_d = StDllp;
        end else if (tlp_fire) begin
          st_d = !tlp_last ? StTlp : (pk_end_pend ? StEndSpill : StIdle);
        end
      end
      StDllp: begin
        if (!active)             st_d = StAbort;
        else if (cnt_q == 3'd1)  st_d = StIdle;
      end
      StTlp: begin
        if (!active)                   st_d = StAbort;
        else if (tlp_valid && tlp_last) st_d = pk_end_pend ? StEndSpill : StIdle;
      end
      StEndSpill: begin
        if (!active)          st_d = StAbort;
        else if (!pk_end_pend) st_d = StIdle;
      end
      StAbort: st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  always_comb begin
    dllp_ready  = 1'b0;
    tlp_ready   = 1'b0;
    pk_raw_en   = 1'b0;
    pk_raw_data = '0;
    pk_raw_k    = '0;
    pk_lead_en  = 1'b0;
    pk_beat_en  = 1'b0;
    pk_end_en   = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (active && !reset) begin
          dllp_ready = 1'b1;
          tlp_ready  = !dllp_valid;
        end
        if (dllp_fire) begin
          pk_raw_en   = 1'b1;
          pk_raw_data = dllp_sym[8*DATA_BYTES-1:0];
          pk_raw_k    = DllpK[DATA_BYTES-1:0];
        end else if (tlp_fire) begin
          pk_lead_en = 1'b1;
          pk_beat_en = 1'b1;
          pk_end_en  = tlp_last;
        end
      end
      StDllp: begin
        if (active) begin
          pk_raw_en   = 1'b1;
          pk_raw_data = dllp_q[8*DATA_BYTES-1:0];
          pk_raw_k    = dllp_kq[DATA_BYTES-1:0];
        end
      end
      StTlp: begin
        if (active) begin
          tlp_ready  = !reset;
          pk_beat_en = tlp_valid;
          pk_end_en  = tlp_valid && tlp_last;
        end
      end
      StEndSpill: pk_end_en = active;
      StAbort: ;
      default: ;
    endcase
    if (abort_now) begin
      pk_raw_en        = 1'b1;
      pk_raw_data      = '0;
      pk_raw_data[7:0] = K_EDB;
      pk_raw_k         = '0;
      pk_raw_k[0]      = 1'b1;
    end
  end

  pipe_tx_byte_packer #(
    .DATA_BYTES (DATA_BYTES),
    .NbW        (NbW)
  ) u_packer (
    .clk_i         (pclk),
    .rst_i         (reset),
    .raw_en_i      (pk_raw_en),
    .raw_data_i    (pk_raw_data),
    .raw_k_i       (pk_raw_k),
    .lead_en_i     (pk_lead_en),
    .beat_en_i     (pk_beat_en),
    .beat_last_i   (tlp_last),
    .beat_nbytes_i (tlp_nbytes),
    .beat_data_i   (tlp_data),
    .end_en_i      (pk_end_en),
    .end_pend_o    (pk_end_pend),
    .tx_data_o     (tx_data),
    .tx_datak_o    (tx_datak)
  );

  assign frame_abort = frame_abort_q;

endmodule
